dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that drives the word-addressed data memory's port (address, write data, write/read strobes) on behalf of the datapath.
- Accepts byte-addressed byte, halfword and word requests over a valid/ready handshake.
- Performs alignment checks and sign/zero extension.
- Implements sub-word stores as read-modify-write, because the memory writes only whole words.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
- ADDR_WORDS, 16, memory depth in 32-bit words; word indices at or above this value are rejected.

Ports:
- SYS_clk  in  1  system clock, all state updates on posedge
- SYS_reset  in  1  asynchronous, active-high reset
- LSU_req_valid  in  1  request present
- LSU_req_ready  out  1  block can accept a request
- LSU_req_write  in  1  1 = store, 0 = load
- LSU_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- LSU_req_signed  in  1  sign-extend load result
- LSU_req_addr  in  32  byte address
- LSU_req_wdata  in  32  store data, right-justified
- LSU_resp_valid  out  1  one-cycle response pulse
- LSU_resp_error  out  1  valid with resp_valid; misaligned, out-of-range or reserved size
- LSU_resp_rdata  out  32  load result; 0 for stores and errors
- LSU_mem_address  out  32  word index, equal to addr[31:2]
- LSU_mem_data_out  out  32  word written to memory
- LSU_mem_write  out  1  memory write strobe
- LSU_mem_read  out  1  memory read enable
- LSU_mem_data_in  in  32  memory read data (combinational in the same cycle)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; all registered fields cleared.
  - While SYS_reset is high every output is 0, including LSU_req_ready.
- FSM states: IDLE, RD, RMW_RD, WR, RESP. Memory-side outputs are decoded from the state and latched request only.
- IDLE:
  - req_ready = 1.
  - A request is accepted on a posedge with valid & ready; addr, size, signed, write and wdata are latched.
- Error classification at acceptance, go to RESP with error = 1 and no memory access, on any of:
  - size 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= ADDR_WORDS.
- Next state from IDLE for a legal request:
  - load -> RD
  - word store -> WR
  - byte/half store -> RMW_RD
- RD:
  - mem_read = 1, mem_address = latched index.
  - At the posedge, extract the lane (little-endian; byte lane = addr[1:0], half lane = addr[1]), zero- or sign-extend to 32 bits into the rdata register -> RESP.
- RMW_RD:
  - mem_read = 1.
  - At the posedge, merge wdata[7:0] or wdata[15:0] into the read word at the lane and register it -> WR.
- WR:
  - mem_write = 1; mem_data_out = merged word, or wdata for a word store.
  - The memory commits at this cycle's posedge -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with no backpressure -> IDLE.
  - resp_rdata holds the load value, otherwise 0.
- Outside RD/RMW_RD/WR, mem_read, mem_write and mem_data_out are 0. mem_address holds the last latched index.
- Latency from acceptance edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- req_ready is 0 outside IDLE. Requests presented while busy are ignored; the requester holds valid.
- Throughput: the earliest next acceptance is the cycle after RESP.
- Reset asserted in WR before the posedge: mem_write drops immediately, no write occurs, no response is issued.
- Reset asserted in RMW_RD: memory is untouched.
- The upper 30 address bits wrap only via the range check; there is no silent wrap.

Optional Feature:
- DMEM_LSU_SUBWORD_EN.
- Defined: byte and half accesses are supported as described above.
- Undefined:
  - sizes 0 and 1 are classified as errors;
  - the RMW_RD state and the lane extract/merge logic are omitted;
  - only word loads and stores reach memory.

Decomposition:
- Package dmem_lsu_pkg:
  - state enum (IDLE, RD, RMW_RD, WR, RESP);
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - misalignment predicate function.
- Sub-module dmem_lsu_align: combinational lane extract/extend for loads and lane merge for stores, instantiated only under DMEM_LSU_SUBWORD_EN.

Test Plan:
- Word store then load: store addr 0x8, wdata 0xDEADBEEF -> mem_write pulse with mem_address 2, resp 2 cycles after acceptance; load addr 0x8 -> rdata 0xDEADBEEF, error 0.
- Byte store RMW: word 2 = 0x11223344; byte store addr 0x9, wdata 0xAB -> RMW_RD then WR with mem_data_out 0x1122AB44, latency 3.
- Signed/unsigned load: word 3 = 0x0000F080; half load addr 0xC -> signed 0xFFFFF080, unsigned 0x0000F080; byte load addr 0xD signed -> 0xFFFFFFF0.
- Errors:
  - word load addr 0x6 -> resp 1 cycle later, error = 1, rdata 0, no mem_read;
  - addr 0x40 with ADDR_WORDS = 16 -> error;
  - size 3 -> error.
- Busy/handshake: second request held valid during WR -> ready = 0 and it is not accepted until after RESP; it is then serviced exactly once.
- Reset mid-write: assert SYS_reset in WR before the posedge -> mem_write low immediately, word unchanged on readback, all outputs 0 while reset is high.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// dmem_lsu_pkg : state encoding, access-size codes and alignment predicate
//                shared by the load/store unit files.
// Revision 1.0
// ============================================================================
package dmem_lsu_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_RD     = 3'd1;
   localparam state_t ST_RMW_RD = 3'd2;
   localparam state_t ST_WR     = 3'd3;
   localparam state_t ST_RESP   = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_HALF: is_misaligned = lo[0];
         SZ_WORD: is_misaligned = |lo;
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// dmem_lsu_if : request/response handshake plus word-memory port of the LSU.
//               master = datapath + memory side, slave = the LSU itself.
// Revision 1.0
// ============================================================================
interface dmem_lsu_if;
   logic        LSU_req_valid;
   logic        LSU_req_ready;
   logic        LSU_req_write;
   logic [1:0]  LSU_req_size;
   logic        LSU_req_signed;
   logic [31:0] LSU_req_addr;
   logic [31:0] LSU_req_wdata;
   logic        LSU_resp_valid;
   logic        LSU_resp_error;
   logic [31:0] LSU_resp_rdata;
   logic [31:0] LSU_mem_address;
   logic [31:0] LSU_mem_data_out;
   logic        LSU_mem_write;
   logic        LSU_mem_read;
   logic [31:0] LSU_mem_data_in;

   modport master (
      output LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_signed,
             LSU_req_addr, LSU_req_wdata, LSU_mem_data_in,
      input  LSU_req_ready, LSU_resp_valid, LSU_resp_error, LSU_resp_rdata,
             LSU_mem_address, LSU_mem_data_out, LSU_mem_write, LSU_mem_read
   );

   modport slave (
      input  LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_signed,
             LSU_req_addr, LSU_req_wdata, LSU_mem_data_in,
      output LSU_req_ready, LSU_resp_valid, LSU_resp_error, LSU_resp_rdata,
             LSU_mem_address, LSU_mem_data_out, LSU_mem_write, LSU_mem_read
   );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu_align.sv
`default_nettype none
// ============================================================================
// dmem_lsu_align : little-endian lane extract/extend for loads and lane merge
//                  for sub-word stores. Exists only with DMEM_LSU_SUBWORD_EN.
// Revision 1.0
// ============================================================================
`ifdef DMEM_LSU_SUBWORD_EN
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  wire logic [1:0]  i_size,
   input  wire logic [1:0]  i_lane,
   input  wire logic        i_signed,
   input  wire logic [31:0] i_mem_word,
   input  wire logic [31:0] i_wdata,
   output logic [31:0]      o_load,
   output logic [31:0]      o_merged
);
   logic [4:0]  w_bsh;
   logic [4:0]  w_hsh;
   logic [31:0] w_shifted;

   assign w_bsh = {i_lane, 3'b000};
   assign w_hsh = {i_lane[1], 4'b0000};

   always_comb begin
      o_load    = i_mem_word;
      o_merged  = i_wdata;
      w_shifted = '0;
      case (i_size)
         SZ_BYTE: begin
            w_shifted = i_mem_word >> w_bsh;
            o_load    = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            o_merged  = (i_mem_word & ~(32'h0000_00FF << w_bsh))
                      | ({24'h0, i_wdata[7:0]} << w_bsh);
         end
         SZ_HALF: begin
            w_shifted = i_mem_word >> w_hsh;
            o_load    = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            o_merged  = (i_mem_word & ~(32'h0000_FFFF << w_hsh))
                      | ({16'h0, i_wdata[15:0]} << w_hsh);
         end
         default: ;
      endcase
   end
endmodule
`endif
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// dmem_lsu : load/store initiator for a word-addressed data memory, with
//            alignment/range checks. Macro DMEM_LSU_SUBWORD_EN adds byte/half
//            accesses (sign/zero extension, read-modify-write stores).
// Revision 1.0
// ============================================================================
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_WORDS = 16
) (
   input  wire logic SYS_clk,
   input  wire logic SYS_reset,
   dmem_lsu_if.slave lsu
);
   state_t      r_state;
   logic [29:0] r_index;
   logic [31:0] r_wword;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_size_err;
   logic        w_range_err;
   logic        w_req_err;
   logic [31:0] w_load_val;
   state_t      w_accept_state;

`ifdef DMEM_LSU_SUBWORD_EN
   logic [1:0]  r_size;
   logic [1:0]  r_lane;
   logic        r_signed;
   logic [31:0] w_merged;

   // r_wword still holds the raw store data while in RMW_RD
   dmem_lsu_align u_align (
      .i_size     (r_size),
      .i_lane     (r_lane),
      .i_signed   (r_signed),
      .i_mem_word (lsu.LSU_mem_data_in),
      .i_wdata    (r_wword),
      .o_load     (w_load_val),
      .o_merged   (w_merged)
   );
   assign w_size_err = (lsu.LSU_req_size == SZ_RSVD);
`else
   assign w_load_val = lsu.LSU_mem_data_in;
   assign w_size_err = (lsu.LSU_req_size != SZ_WORD);
`endif

   assign w_range_err = ({2'b00, lsu.LSU_req_addr[31:2]} >= 32'(ADDR_WORDS));
   assign w_req_err   = w_size_err | w_range_err
                      | is_misaligned(lsu.LSU_req_size, lsu.LSU_req_addr[1:0]);
   assign w_accept    = lsu.LSU_req_valid && (r_state == ST_IDLE);

   always_comb begin
      if (w_req_err)
         w_accept_state = ST_RESP;
      else if (!lsu.LSU_req_write)
         w_accept_state = ST_RD;
`ifdef DMEM_LSU_SUBWORD_EN
      else if (lsu.LSU_req_size != SZ_WORD)
         w_accept_state = ST_RMW_RD;
`endif
      else
         w_accept_state = ST_WR;
   end

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         r_state  <= ST_IDLE;
         r_index  <= '0;
         r_wword  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
`ifdef DMEM_LSU_SUBWORD_EN
         r_size   <= '0;
         r_lane   <= '0;
         r_signed <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= w_accept_state;
                  r_index  <= lsu.LSU_req_addr[31:2];
                  r_wword  <= lsu.LSU_req_wdata;
                  r_rdata  <= '0;
                  r_err    <= w_req_err;
`ifdef DMEM_LSU_SUBWORD_EN
                  r_size   <= lsu.LSU_req_size;
                  r_lane   <= lsu.LSU_req_addr[1:0];
                  r_signed <= lsu.LSU_req_signed;
`endif
               end
            end
            ST_RD: begin
               r_rdata <= w_load_val;
               r_state <= ST_RESP;
            end
`ifdef DMEM_LSU_SUBWORD_EN
            ST_RMW_RD: begin
               r_wword <= w_merged;
               r_state <= ST_WR;
            end
`endif
            ST_WR:   r_state <= ST_RESP;
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // registers are cleared asynchronously, so only ready needs explicit gating
   assign lsu.LSU_req_ready    = (r_state == ST_IDLE) && !SYS_reset;
   assign lsu.LSU_resp_valid   = (r_state == ST_RESP);
   assign lsu.LSU_resp_error   = (r_state == ST_RESP) && r_err;
   assign lsu.LSU_resp_rdata   = (r_state == ST_RESP) ? r_rdata : 32'h0;
   assign lsu.LSU_mem_address  = {2'b00, r_index};
   assign lsu.LSU_mem_read     = (r_state == ST_RD) || (r_state == ST_RMW_RD);
   assign lsu.LSU_mem_write    = (r_state == ST_WR);
   assign lsu.LSU_mem_data_out = (r_state == ST_WR) ? r_wword : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// tb_dmem_lsu : self-checking bench for dmem_lsu; a byte-array reference model
//               predicts every response, latency and memory write.
// Revision 1.0
// ============================================================================
module tb_dmem_lsu;
    localparam int ADDR_WORDS = 16;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  lat;
        logic [7:0]  nwr;
        logic [7:0]  nrd;
        logic [31:0] wword;
        logic [31:0] waddr;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu #(.ADDR_WORDS(ADDR_WORDS)) dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .lsu       (bus)
    );

    // environment memory: combinational read, write on posedge
    logic [31:0] tbmem [ADDR_WORDS] = '{default: 32'h0};
    always @(posedge clk)
        if (bus.LSU_mem_write && bus.LSU_mem_address < ADDR_WORDS)
            tbmem[bus.LSU_mem_address[3:0]] <= bus.LSU_mem_data_out;
    assign bus.LSU_mem_data_in = (bus.LSU_mem_address < ADDR_WORDS) ?
                                 tbmem[bus.LSU_mem_address[3:0]] : 32'h0;

    // reference model: memory seen as bytes
    logic [7:0] ref_b [ADDR_WORDS*4] = '{default: 8'h00};

    function automatic obs_t ref_req(input req_t r);
        obs_t        e;
        int          n;
        logic [31:0] v;
        e = '0;
        n = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : (r.sz == 2'd2) ? 4 : 0;
`ifndef DMEM_LSU_SUBWORD_EN
        if (n < 4) n = 0;
`endif
        if (n == 0 || (r.addr % n) != 0 || (r.addr / 4) >= ADDR_WORDS) begin
            e.err = 1'b1;
            e.lat = 8'd1;
            return e;
        end
        if (!r.wr) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[r.addr + i]) << (8 * i));
            if (r.sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.lat   = 8'd2;
            e.nrd   = 8'd1;
        end else begin
            for (int i = 0; i < n; i++) ref_b[r.addr + i] = 8'(r.wd >> (8 * i));
            for (int i = 0; i < 4; i++)
                e.wword = e.wword | (32'(ref_b[(r.addr & ~32'd3) + i]) << (8 * i));
            e.waddr = r.addr >> 2;
            e.nwr   = 8'd1;
            e.lat   = (n == 4) ? 8'd2 : 8'd3;
            e.nrd   = (n == 4) ? 8'd0 : 8'd1;
        end
        return e;
    endfunction

    function automatic logic [100:0] all_outs();
        return {bus.LSU_req_ready, bus.LSU_resp_valid, bus.LSU_resp_error,
                bus.LSU_resp_rdata, bus.LSU_mem_address, bus.LSU_mem_data_out,
                bus.LSU_mem_write, bus.LSU_mem_read};
    endfunction

    // drives one request and records what the DUT does until its response
    task automatic drive_req(input req_t r, output obs_t o, output bit to);
        int w;
        bit got;
        o = '0; to = 1'b0; got = 1'b0;
        @(negedge clk);
        bus.LSU_req_valid  = 1'b1;
        bus.LSU_req_write  = r.wr;
        bus.LSU_req_size   = r.sz;
        bus.LSU_req_signed = r.sg;
        bus.LSU_req_addr   = r.addr;
        bus.LSU_req_wdata  = r.wd;
        w = 0;
        while (!bus.LSU_req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.LSU_req_ready) begin
            bus.LSU_req_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(posedge clk);
        #1 bus.LSU_req_valid = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (bus.LSU_mem_write) begin
                o.nwr   = o.nwr + 8'd1;
                o.wword = bus.LSU_mem_data_out;
                o.waddr = bus.LSU_mem_address;
            end
            if (bus.LSU_mem_read) o.nrd = o.nrd + 8'd1;
            if (bus.LSU_resp_valid) begin
                got     = 1'b1;
                o.lat   = 8'(c);
                o.err   = bus.LSU_resp_error;
                o.rdata = bus.LSU_resp_rdata;
            end
        end
        to = !got;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp 0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== {1'b1, 100'h0}) begin
            errors++;
            $display("FAIL reset_release: got %h exp %h", all_outs(), {1'b1, 100'h0});
        end
    endtask

    task automatic test_word();
        req_t t [2];
        obs_t o [2];
        obs_t e;
        bit   to;
        t[0] = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF};
        t[1] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0};
        for (int i = 0; i < 2; i++) begin
            e = ref_req(t[i]);
            drive_req(t[i], o[i], to);
            checks++;
            if (to || o[i] !== e) begin
                errors++;
                $display("FAIL word_%0d: timeout=%0d got %h exp %h", i, to, o[i], e);
            end
        end
        checks++;
        if (o[0].waddr !== 32'd2 || o[0].lat !== 8'd2 || o[0].wword !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_store_const: got addr %h lat %0d data %h exp 2 2 deadbeef",
                     o[0].waddr, o[0].lat, o[0].wword);
        end
        checks++;
        if (o[1].rdata !== 32'hDEAD_BEEF || o[1].err !== 1'b0 || o[1].lat !== 8'd2) begin
            errors++;
            $display("FAIL word_load_const: got %h err %b lat %0d exp deadbeef 0 2",
                     o[1].rdata, o[1].err, o[1].lat);
        end
    endtask

    task automatic test_subword();
        req_t t [7];
        obs_t o [7];
        obs_t e;
        bit   to;
        t[0] = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344};
        t[1] = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AB};
        t[2] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0};
        t[3] = '{1'b1, 2'd2, 1'b0, 32'hC, 32'h0000_F080};
        t[4] = '{1'b0, 2'd1, 1'b1, 32'hC, 32'h0};
        t[5] = '{1'b0, 2'd1, 1'b0, 32'hC, 32'h0};
        t[6] = '{1'b0, 2'd0, 1'b1, 32'hD, 32'h0};
        for (int i = 0; i < 7; i++) begin
            e = ref_req(t[i]);
            drive_req(t[i], o[i], to);
            checks++;
            if (to || o[i] !== e) begin
                errors++;
                $display("FAIL subword_%0d: timeout=%0d got %h exp %h", i, to, o[i], e);
            end
        end
`ifdef DMEM_LSU_SUBWORD_EN
        checks++;
        if (o[1].wword !== 32'h1122_AB44 || o[1].lat !== 8'd3 || o[1].nrd !== 8'd1) begin
            errors++;
            $display("FAIL byte_rmw_const: got %h lat %0d exp 1122ab44 lat 3",
                     o[1].wword, o[1].lat);
        end
        checks++;
        if ({o[4].rdata, o[5].rdata, o[6].rdata} !== {32'hFFFF_F080, 32'h0000_F080, 32'hFFFF_FFF0}) begin
            errors++;
            $display("FAIL ext_loads_const: got %h %h %h exp fffff080 0000f080 fffffff0",
                     o[4].rdata, o[5].rdata, o[6].rdata);
        end
`else
        checks++;
        if ({o[1].err, o[4].err, o[5].err, o[6].err} !== 4'hF || o[2].rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL subword_disabled: got errs %b word %h exp 1111 11223344",
                     {o[1].err, o[4].err, o[5].err, o[6].err}, o[2].rdata);
        end
`endif
    endtask

    task automatic test_errors();
        req_t t [5];
        obs_t o;
        obs_t e;
        bit   to;
        t[0] = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0};
        t[1] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0};
        t[2] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0};
        t[3] = '{1'b1, 2'd1, 1'b0, 32'h3, 32'h1234};
        t[4] = '{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h5555_AAAA};
        for (int i = 0; i < 5; i++) begin
            e = ref_req(t[i]);
            drive_req(t[i], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("FAIL error_model_%0d: timeout=%0d got %h exp %h", i, to, o, e);
            end
            checks++;
            if ({o.err, o.lat, o.nrd, o.nwr, o.rdata} !== {1'b1, 8'd1, 8'd0, 8'd0, 32'h0}) begin
                errors++;
                $display("FAIL error_const_%0d: got err %b lat %0d rd %0d wr %0d data %h exp 1 1 0 0 0",
                         i, o.err, o.lat, o.nrd, o.nwr, o.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t        a;
        obs_t        e;
        int          nresp, nwr, bad_ready, rsp1, rsp2;
        logic [31:0] rd2;
        bit          drop;
        a = '{1'b1, 2'd2, 1'b0, 32'h14, $urandom};
        e = ref_req(a);
        nresp = 0; nwr = 0; bad_ready = 0; rsp1 = 0; rsp2 = 0; rd2 = '0;
        @(negedge clk);
        checks++;
        if (bus.LSU_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready: got %b exp 1", bus.LSU_req_ready);
        end
        bus.LSU_req_valid  = 1'b1;
        bus.LSU_req_write  = a.wr;
        bus.LSU_req_size   = a.sz;
        bus.LSU_req_signed = a.sg;
        bus.LSU_req_addr   = a.addr;
        bus.LSU_req_wdata  = a.wd;
        @(posedge clk);
        #1;
        bus.LSU_req_write = 1'b0;
        bus.LSU_req_wdata = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.LSU_mem_write) nwr++;
            if (bus.LSU_resp_valid) begin
                nresp++;
                if (nresp == 1) rsp1 = c;
                else begin
                    rsp2 = c;
                    rd2  = bus.LSU_resp_rdata;
                end
            end
            if (bus.LSU_req_ready && c != 3 && c <= 5) bad_ready++;
            drop = bus.LSU_req_ready && bus.LSU_req_valid;
            @(posedge clk);
            #1 if (drop) bus.LSU_req_valid = 1'b0;
        end
        bus.LSU_req_valid = 1'b0;
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL b2b_ready_busy: got %0d ready cycles while busy exp 0", bad_ready);
        end
        checks++;
        if (nresp != 2 || rsp1 != 2 || rsp2 != 5) begin
            errors++;
            $display("FAIL b2b_resp_timing: got %0d resps at %0d,%0d exp 2 at 2,5", nresp, rsp1, rsp2);
        end
        checks++;
        if (nwr != 1 || rd2 !== e.wword) begin
            errors++;
            $display("FAIL b2b_data: got writes %0d rdata %h exp 1 %h", nwr, rd2, e.wword);
        end
    endtask

    task automatic test_reset_mid_write();
        req_t p, l;
        obs_t o, e;
        bit   to;
        p = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h0BAD_F00D};
        l = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
        e = ref_req(p);
        drive_req(p, o, to);
        checks++;
        if (to || o !== e) begin
            errors++;
            $display("FAIL rstwr_preload: timeout=%0d got %h exp %h", to, o, e);
        end
        @(negedge clk);
        bus.LSU_req_valid  = 1'b1;
        bus.LSU_req_write  = 1'b1;
        bus.LSU_req_size   = 2'd2;
        bus.LSU_req_addr   = 32'h10;
        bus.LSU_req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1 bus.LSU_req_valid = 1'b0;
        checks++;
        if (bus.LSU_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rstwr_in_wr: got mem_write %b exp 1", bus.LSU_mem_write);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL rstwr_immediate: got %h exp 0", all_outs());
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== '0 || tbmem[4] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rstwr_held: got %h mem %h exp 0 0badf00d", all_outs(), tbmem[4]);
        end
        rst = 1'b0;
        e = ref_req(l);
        drive_req(l, o, to);
        checks++;
        if (to || o !== e || o.rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rstwr_readback: timeout=%0d got %h exp %h", to, o, e);
        end
    endtask

    task automatic test_random();
        req_t r;
        obs_t o, e;
        bit   to;
        for (int i = 0; i < 80; i++) begin
            r.wr   = 1'($urandom_range(0, 1));
            r.sz   = 2'($urandom_range(0, 3));
            r.sg   = 1'($urandom_range(0, 1));
            r.addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) r.addr = r.addr | 32'h8000_0000;
            r.wd   = $urandom;
            e = ref_req(r);
            drive_req(r, o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("FAIL random_%0d: req %h timeout=%0d got %h exp %h", i, r, to, o, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.LSU_req_valid  = 1'b0;
        bus.LSU_req_write  = 1'b0;
        bus.LSU_req_size   = 2'd0;
        bus.LSU_req_signed = 1'b0;
        bus.LSU_req_addr   = 32'h0;
        bus.LSU_req_wdata  = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
